// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the execute stage: ALU operations, branch
// funct3 values, forwarding selects and writeback result selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_SLT   = 4'h5,
        ALU_SLTU  = 4'h6,
        ALU_SLL   = 4'h7,
        ALU_SRL   = 4'h8,
        ALU_SRA   = 4'h9,
        ALU_PASSB = 4'hA
    } alu_op_e;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        FWD_NONE     = 2'b00,
        FWD_WB       = 2'b01,
        FWD_MEM      = 2'b10,
        FWD_NONE_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; unassigned operation codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_op_e               op,
    output logic [DATA_WIDTH-1:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $signed(a) >>> shamt;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register with flush and stall control.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ValidE_i,
    input  logic                      RegWriteE_i,
    input  logic [1:0]                ResultSrcE_i,
    input  logic                      MemWriteE_i,
    input  logic                      JumpE_i,
    input  logic                      JalrE_i,
    input  logic                      BranchE_i,
    input  logic [2:0]                BranchTypeE_i,
    input  logic [3:0]                ALUControlE_i,
    input  logic                      ALUSrcE_i,
    input  logic [DATA_WIDTH-1:0]     RD1E_i,
    input  logic [DATA_WIDTH-1:0]     RD2E_i,
    input  logic [DATA_WIDTH-1:0]     PCE_i,
    input  logic [DATA_WIDTH-1:0]     ImmExtE_i,
    input  logic [DATA_WIDTH-1:0]     PCPlus4E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic [1:0]                ForwardAE_i,
    input  logic [1:0]                ForwardBE_i,
    input  logic [DATA_WIDTH-1:0]     ResultW_i,
    input  logic                      StallM_i,
    input  logic                      FlushM_i,
    output logic                      PCSrcE_o,
    output logic [DATA_WIDTH-1:0]     PCTargetE_o,
    output logic                      ValidM_o,
    output logic                      RegWriteM_o,
    output logic                      MemWriteM_o,
    output logic [1:0]                ResultSrcM_o,
    output logic [DATA_WIDTH-1:0]     ALUResultM_o,
    output logic [DATA_WIDTH-1:0]     WriteDataM_o,
    output logic [DATA_WIDTH-1:0]     PCPlus4M_o,
    output logic [REG_ADDR_WIDTH-1:0] RdM_o
);

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_write;
        result_src_e               result_src;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     write_data;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } ex_mem_t;

    ex_mem_t               ex_mem_d, ex_mem_q;
    logic [DATA_WIDTH-1:0] src_a, src_b, write_data_e, alu_result_e;
    logic [DATA_WIDTH-1:0] target_base, target_sum;
    logic                  branch_cond;

    function automatic logic [DATA_WIDTH-1:0] fwd_mux(
        input fwd_sel_e              sel,
        input logic [DATA_WIDTH-1:0] rd,
        input logic [DATA_WIDTH-1:0] wb,
        input logic [DATA_WIDTH-1:0] mem
    );
        case (sel)
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rd;
        endcase
    endfunction

    // The M-stage forward uses the live register contents, so it stays correct while stalled.
    assign src_a        = fwd_mux(fwd_sel_e'(ForwardAE_i), RD1E_i, ResultW_i, ex_mem_q.alu_result);
    assign write_data_e = fwd_mux(fwd_sel_e'(ForwardBE_i), RD2E_i, ResultW_i, ex_mem_q.alu_result);
    assign src_b        = ALUSrcE_i ? ImmExtE_i : write_data_e;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a      (src_a),
        .b      (src_b),
        .op     (alu_op_e'(ALUControlE_i)),
        .result (alu_result_e)
    );

    // Branches compare the two register operands, never the immediate.
    always_comb begin
        branch_cond = 1'b0;
        case (BranchTypeE_i)
            BR_BEQ:  branch_cond = (src_a == write_data_e);
            BR_BNE:  branch_cond = (src_a != write_data_e);
            BR_BLT:  branch_cond = ($signed(src_a) < $signed(write_data_e));
            BR_BGE:  branch_cond = ($signed(src_a) >= $signed(write_data_e));
            BR_BLTU: branch_cond = (src_a < write_data_e);
            BR_BGEU: branch_cond = (src_a >= write_data_e);
            default: branch_cond = 1'b0;
        endcase
    end

    assign PCSrcE_o    = ValidE_i & (JumpE_i | (BranchE_i & branch_cond));
    assign target_base = JalrE_i ? src_a : PCE_i;
    assign target_sum  = target_base + ImmExtE_i;
    assign PCTargetE_o = {target_sum[DATA_WIDTH-1:1], target_sum[0] & ~JalrE_i};

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (FlushM_i) begin
            ex_mem_d = '0;
        end else if (!StallM_i) begin
            ex_mem_d.valid      = ValidE_i;
            ex_mem_d.reg_write  = ValidE_i & RegWriteE_i & (RdE_i != '0);
            ex_mem_d.mem_write  = ValidE_i & MemWriteE_i;
            ex_mem_d.result_src = result_src_e'(ResultSrcE_i);
            ex_mem_d.alu_result = alu_result_e;
            ex_mem_d.write_data = write_data_e;
            ex_mem_d.pc_plus4   = PCPlus4E_i;
            ex_mem_d.rd         = RdE_i;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the whole register, data included, is reset so a reset mid-operation leaves no stale result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign ValidM_o     = ex_mem_q.valid;
    assign RegWriteM_o  = ex_mem_q.reg_write;
    assign MemWriteM_o  = ex_mem_q.mem_write;
    assign ResultSrcM_o = ex_mem_q.result_src;
    assign ALUResultM_o = ex_mem_q.alu_result;
    assign WriteDataM_o = ex_mem_q.write_data;
    assign PCPlus4M_o   = ex_mem_q.pc_plus4;
    assign RdM_o        = ex_mem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push hand-computed
// EX/MEM expectations; a monitor pops and compares after each rising edge.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidE_i, RegWriteE_i, MemWriteE_i, JumpE_i, JalrE_i, BranchE_i, ALUSrcE_i;
    logic [1:0]  ResultSrcE_i, ForwardAE_i, ForwardBE_i;
    logic [2:0]  BranchTypeE_i;
    logic [3:0]  ALUControlE_i;
    logic [31:0] RD1E_i, RD2E_i, PCE_i, ImmExtE_i, PCPlus4E_i, ResultW_i;
    logic [4:0]  RdE_i;
    logic        StallM_i, FlushM_i;
    logic        PCSrcE_o, ValidM_o, RegWriteM_o, MemWriteM_o;
    logic [31:0] PCTargetE_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o;
    logic [1:0]  ResultSrcM_o;
    logic [4:0]  RdM_o;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mw;
        logic [1:0]  rsrc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } m_t;

    typedef struct {
        string name;
        m_t    m;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .ValidE_i(ValidE_i), .RegWriteE_i(RegWriteE_i), .ResultSrcE_i(ResultSrcE_i),
        .MemWriteE_i(MemWriteE_i), .JumpE_i(JumpE_i), .JalrE_i(JalrE_i),
        .BranchE_i(BranchE_i), .BranchTypeE_i(BranchTypeE_i), .ALUControlE_i(ALUControlE_i),
        .ALUSrcE_i(ALUSrcE_i), .RD1E_i(RD1E_i), .RD2E_i(RD2E_i), .PCE_i(PCE_i),
        .ImmExtE_i(ImmExtE_i), .PCPlus4E_i(PCPlus4E_i), .RdE_i(RdE_i),
        .ForwardAE_i(ForwardAE_i), .ForwardBE_i(ForwardBE_i), .ResultW_i(ResultW_i),
        .StallM_i(StallM_i), .FlushM_i(FlushM_i),
        .PCSrcE_o(PCSrcE_o), .PCTargetE_o(PCTargetE_o),
        .ValidM_o(ValidM_o), .RegWriteM_o(RegWriteM_o), .MemWriteM_o(MemWriteM_o),
        .ResultSrcM_o(ResultSrcM_o), .ALUResultM_o(ALUResultM_o),
        .WriteDataM_o(WriteDataM_o), .PCPlus4M_o(PCPlus4M_o), .RdM_o(RdM_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic m_t em(input logic v, input logic rw, input logic mw, input logic [1:0] rs,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic [31:0] pc4, input logic [4:0] rd);
        return '{valid: v, rw: rw, mw: mw, rsrc: rs, alu: alu, wd: wd, pc4: pc4, rd: rd};
    endfunction

    function automatic m_t dut_m();
        return '{valid: ValidM_o, rw: RegWriteM_o, mw: MemWriteM_o, rsrc: ResultSrcM_o,
                 alu: ALUResultM_o, wd: WriteDataM_o, pc4: PCPlus4M_o, rd: RdM_o};
    endfunction

    task automatic set_in(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                          input logic j, input logic jr, input logic br, input logic [2:0] bt,
                          input logic [3:0] op, input logic asrc,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] pc4, input logic [4:0] rd,
                          input logic [1:0] fa, input logic [1:0] fb);
        ValidE_i = v; RegWriteE_i = rw; ResultSrcE_i = rs; MemWriteE_i = mw;
        JumpE_i = j; JalrE_i = jr; BranchE_i = br; BranchTypeE_i = bt;
        ALUControlE_i = op; ALUSrcE_i = asrc; RD1E_i = rd1; RD2E_i = rd2; PCE_i = pc;
        ImmExtE_i = imm; PCPlus4E_i = pc4; RdE_i = rd; ForwardAE_i = fa; ForwardBE_i = fb;
        #1;
    endtask

    // Push the expected EX/MEM contents for the coming edge, then advance one cycle.
    task automatic cycle(input string name, input m_t e);
        sb_q.push_back('{name: name, m: e});
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, dut_m(), e.m);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        m_t held;
        rst = 1'b1; StallM_i = 1'b0; FlushM_i = 1'b0; ResultW_i = '0;
        set_in(0,0,0,0, 0,0,0,3'b000, 4'h0,0, 0,0,0,0,0,0, 0,0);
        #1;
        check("reset_state", dut_m(), '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // ALU and forwarding
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h0,1, 0,0, 0,5,4,1, 0,0);
        cycle("addi_x1_5", em(1,1,0,0, 32'h5,0,32'h4,1));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h0,0, 32'hDEAD,7, 4,32'h99,8,3, 2'b10,0);
        check("add_fwd_m_pcsrc", PCSrcE_o, 0);
        cycle("add_fwd_m", em(1,1,0,0, 32'd12,7,32'h8,3));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h1,0, 0,1, 8,0,32'hC,4, 0,0);
        cycle("sub_wrap", em(1,1,0,0, 32'hFFFF_FFFF,1,32'hC,4));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h9,1, 32'h8000_0000,32'h55, 32'hC,4,32'h10,5, 0,0);
        cycle("sra_by4", em(1,1,0,0, 32'hF800_0000,32'h55,32'h10,5));
        ResultW_i = 32'h30;
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h4,0, 32'h10,1, 32'h10,0,32'h14,6, 0,2'b01);
        cycle("xor_fwd_w", em(1,1,0,0, 32'h20,32'h30,32'h14,6));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h5,0, 32'hFFFF_FFFF,1, 0,0,32'h18,7, 2'b11,2'b11);
        cycle("slt_signed", em(1,1,0,0, 32'h1,1,32'h18,7));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h6,0, 32'hFFFF_FFFF,1, 0,0,32'h18,7, 0,0);
        cycle("sltu", em(1,1,0,0, 32'h0,1,32'h18,7));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h7,1, 1,9, 0,32'h23,32'h1C,8, 0,0);
        cycle("sll_shamt_low5", em(1,1,0,0, 32'h8,9,32'h1C,8));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'hC,1, 3,9, 0,7,32'h1C,8, 0,0);
        cycle("illegal_op_zero", em(1,1,0,0, 32'h0,9,32'h1C,8));
        set_in(1,1,0,0, 0,0,0,3'b000, 4'hA,1, 3,9, 0,32'hABCD_E000,32'h20,8, 0,0);
        cycle("passb_lui", em(1,1,0,0, 32'hABCD_E000,9,32'h20,8));

        // Branches
        set_in(1,0,0,0, 0,0,1,3'b100, 4'h1,0, 32'hFFFF_FFFF,1, 32'h100,32'h20,32'h104,0, 0,0);
        check("blt_taken", PCSrcE_o, 1);
        check("blt_target", PCTargetE_o, 32'h120);
        cycle("blt_reg", em(1,0,0,0, 32'hFFFF_FFFE,1,32'h104,0));
        set_in(1,0,0,0, 0,0,1,3'b110, 4'h1,0, 32'hFFFF_FFFF,1, 32'h100,32'h20,32'h104,0, 0,0);
        check("bltu_not_taken", PCSrcE_o, 0);
        set_in(0,0,0,0, 0,0,1,3'b100, 4'h1,0, 32'hFFFF_FFFF,1, 32'h100,32'h20,32'h104,0, 0,0);
        check("blt_bubble", PCSrcE_o, 0);
        cycle("bubble_reg", em(0,0,0,0, 32'hFFFF_FFFE,1,32'h104,0));
        set_in(1,0,0,0, 0,0,1,3'b101, 4'h1,0, 32'hFFFF_FFFF,1, 32'h100,32'h20,32'h104,0, 0,0);
        check("bge_not_taken", PCSrcE_o, 0);
        set_in(1,0,0,0, 0,0,1,3'b111, 4'h1,0, 32'hFFFF_FFFF,1, 32'h100,32'h20,32'h104,0, 0,0);
        check("bgeu_taken", PCSrcE_o, 1);
        set_in(1,0,0,0, 0,0,1,3'b000, 4'h1,1, 32'h20,32'h21, 32'h100,32'h20,32'h104,0, 0,0);
        check("beq_ignores_imm", PCSrcE_o, 0);
        set_in(1,0,0,0, 0,0,1,3'b001, 4'h1,1, 32'h20,32'h21, 32'h100,32'h20,32'h104,0, 0,0);
        check("bne_taken", PCSrcE_o, 1);
        set_in(1,0,0,0, 0,0,1,3'b010, 4'h1,0, 5,5, 32'h100,32'h20,32'h104,0, 0,0);
        check("funct3_010_never", PCSrcE_o, 0);

        // Jumps
        set_in(1,1,2'b10,0, 1,1,0,3'b000, 4'h0,1, 32'h1001,0, 32'h200,4,32'h204,1, 0,0);
        check("jalr_taken", PCSrcE_o, 1);
        check("jalr_target", PCTargetE_o, 32'h1004);
        cycle("jalr_reg", em(1,1,0,2'b10, 32'h1005,0,32'h204,1));
        set_in(1,1,2'b10,0, 1,0,0,3'b000, 4'h0,1, 0,0, 32'h300,32'h11,32'h304,1, 0,0);
        check("jal_target_odd", PCTargetE_o, 32'h311);
        set_in(0,1,2'b10,0, 1,0,0,3'b000, 4'h0,1, 0,0, 32'h300,32'h11,32'h304,1, 0,0);
        check("jal_bubble", PCSrcE_o, 0);

        // Writeback and store qualification
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h0,1, 3,0, 0,4,32'h8,0, 0,0);
        cycle("x0_write_suppressed", em(1,0,0,0, 32'h7,0,32'h8,0));
        set_in(1,0,0,1, 0,0,0,3'b000, 4'h0,1, 32'h1000,32'hCAFE, 0,8,32'h4,0, 0,0);
        cycle("store", em(1,0,1,0, 32'h1008,32'hCAFE,32'h4,0));
        set_in(0,0,0,1, 0,0,0,3'b000, 4'h0,1, 32'h1000,32'hCAFE, 0,8,32'h4,0, 0,0);
        cycle("store_bubble", em(0,0,0,0, 32'h1008,32'hCAFE,32'h4,0));

        // Stall holds the register; forwarding from M still sees held data
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h0,1, 32'h100,0, 32'h40,32'h23,32'h44,7, 0,0);
        held = em(1,1,0,0, 32'h123,0,32'h44,7);
        cycle("pre_stall", held);
        StallM_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1,1,2'b01,1, 1,1,0,3'b000, 4'h1,1, 32'h999+i,i, 0,1,32'h50,9, 2'b10,0);
            check("stall_fwd_target", PCTargetE_o, 32'h124);
            check("stall_pcsrc", PCSrcE_o, 1);
            cycle("stall_hold", held);
        end
        StallM_i = 1'b0;
        set_in(1,1,0,0, 0,0,0,3'b000, 4'h0,1, 0,0, 0,1,32'h48,8, 2'b10,0);
        cycle("post_stall_fwd", em(1,1,0,0, 32'h124,0,32'h48,8));
        StallM_i = 1'b1; FlushM_i = 1'b1;
        set_in(1,1,2'b01,1, 0,0,0,3'b000, 4'h0,1, 5,6, 0,1,32'h4C,9, 0,0);
        cycle("stall_and_flush", '0);
        StallM_i = 1'b0; FlushM_i = 1'b0;
        cycle("reload", em(1,1,1,2'b01, 32'h6,6,32'h4C,9));
        FlushM_i = 1'b1;
        cycle("flush_only", '0);
        FlushM_i = 1'b0;

        // Asynchronous reset between edges
        set_in(1,1,2'b01,1, 0,0,0,3'b000, 4'h3,1, 32'hF0,32'h77, 0,32'hF,32'h64,12, 0,0);
        cycle("pre_reset", em(1,1,1,2'b01, 32'hFF,32'h77,32'h64,12));
        rst = 1'b1;
        #1;
        check("async_reset_clear", dut_m(), '0);
        #1;
        rst = 1'b0;
        cycle("post_reset_load", em(1,1,1,2'b01, 32'hFF,32'h77,32'h64,12));

        set_in(0,0,0,0, 0,0,0,3'b000, 4'h0,0, 0,0,0,0,0,0, 0,0);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
